// File: rtl/sort_streamer.sv
// sort_streamer: collects an 8-byte frame from a valid/ready stream, loads it
// into the external byte sorter, starts it, then reads the sorted bytes back
// out as a valid/ready stream with a last-byte marker.
module sort_streamer #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int READ_LAT = 2
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              s_start,
   output logic              s_wr,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_datain,
   input  logic [DATA_W-1:0] s_dataout,
   input  logic              s_ready
);

   localparam int                N         = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
   localparam int                LAT_W     = $clog2(READ_LAT + 2);

   typedef enum logic [2:0] {
      LOAD   = 3'd0,
      SETTLE = 3'd1,
      GO     = 3'd2,
      WAIT   = 3'd3,
      FETCH  = 3'd4,
      EMIT   = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_cnt;
   logic [LAT_W-1:0]    r_lat;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_last;
   logic                r_busy;
   logic                r_s_start;
   logic                r_s_wr;
   logic [ADDR_W-1:0]   r_s_addr;
   logic [DATA_W-1:0]   r_s_datain;

   logic                w_accept;
   logic                w_lat_done;
   logic                w_out_xfer;
   logic                w_last_addr;

   assign w_accept    = in_valid && (r_state == LOAD);
   assign w_lat_done  = (r_lat == LAT_W'(READ_LAT));
   assign w_out_xfer  = r_out_valid && out_ready;
   assign w_last_addr = (r_s_addr == LAST_ADDR);

   assign in_ready  = (r_state == LOAD);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign busy      = r_busy;
   assign s_start   = r_s_start;
   assign s_wr      = r_s_wr;
   assign s_addr    = r_s_addr;
   assign s_datain  = r_s_datain;

   // State register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= LOAD;
      else       r_state <= w_next;
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         LOAD:    if (w_accept && (r_cnt == LAST_ADDR)) w_next = SETTLE;
         SETTLE:  w_next = GO;
         GO:      w_next = WAIT;
         WAIT:    if (s_ready) w_next = FETCH;
         FETCH:   if (w_lat_done) w_next = EMIT;
         EMIT:    if (w_out_xfer) w_next = w_last_addr ? LOAD : FETCH;
         default: w_next = LOAD;
      endcase
   end

   // Registered outputs and counters; values are those of the state being entered
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_cnt       <= '0;
         r_lat       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
         r_s_start   <= 1'b0;
         r_s_wr      <= 1'b0;
         r_s_addr    <= '0;
         r_s_datain  <= '0;
      end else begin
         case (r_state)
            LOAD: begin
               r_s_wr <= w_accept;
               if (w_accept) begin
                  r_s_addr   <= r_cnt;
                  r_s_datain <= in_data;
                  r_cnt      <= r_cnt + ADDR_W'(1);
                  r_busy     <= 1'b1;
               end
            end
            SETTLE: begin
               // last write has been presented; start only once s_wr drops
               r_s_wr    <= 1'b0;
               r_s_start <= 1'b1;
            end
            GO: begin
               r_s_start <= 1'b0;
            end
            WAIT: begin
               if (s_ready) begin
                  r_s_addr <= '0;
                  r_s_wr   <= 1'b0;
                  r_lat    <= '0;
               end
            end
            FETCH: begin
               // s_addr is held; data is valid READ_LAT edges after first sample
               if (w_lat_done) begin
                  r_out_data  <= s_dataout;
                  r_out_valid <= 1'b1;
                  r_out_last  <= w_last_addr;
               end else begin
                  r_lat <= r_lat + LAT_W'(1);
               end
            end
            EMIT: begin
               if (w_out_xfer) begin
                  r_out_valid <= 1'b0;
                  r_lat       <= '0;
                  if (w_last_addr) begin
                     r_busy     <= 1'b0;
                     r_out_last <= 1'b0;
                     r_s_addr   <= '0;
                  end else begin
                     r_s_addr <= r_s_addr + ADDR_W'(1);
                  end
               end
            end
            default: begin
               r_s_start <= 1'b0;
               r_s_wr    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sort_streamer.sv
// Bench for sort_streamer: behavioural sorter model, directed and random
// frames, expected output derived by counting byte occurrences.
module tb_sort_streamer;

   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 3;
   localparam int READ_LAT = 2;
   localparam int N        = 8;

   logic              clk = 1'b0;
   logic              nrst = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;
   logic              s_start;
   logic              s_wr;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_datain;
   logic [DATA_W-1:0] s_dataout;
   logic              s_ready;

   always #5 clk = ~clk;

   sort_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
      .clk(clk), .nrst(nrst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy),
      .s_start(s_start), .s_wr(s_wr), .s_addr(s_addr), .s_datain(s_datain),
      .s_dataout(s_dataout), .s_ready(s_ready)
   );

   // Behavioural sorter: registered write port, 2-edge read, sorts some cycles after start
   logic [7:0] smem [N];
   logic       p_wr;
   logic [2:0] p_addr;
   logic [7:0] p_din;
   logic [7:0] rd1;
   int         scnt;
   logic [7:0] sq[$];

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         s_ready   <= 1'b1;
         p_wr      <= 1'b0;
         p_addr    <= '0;
         p_din     <= '0;
         rd1       <= '0;
         s_dataout <= '0;
         scnt      <= 0;
      end else begin
         p_wr   <= s_wr;
         p_addr <= s_addr;
         p_din  <= s_datain;
         if (p_wr) smem[p_addr] <= p_din;
         rd1       <= smem[s_addr];
         s_dataout <= rd1;
         if (s_start) begin
            s_ready <= 1'b0;
            scnt    <= int'($urandom_range(3, 12));
         end else if (!s_ready) begin
            if (scnt == 0) begin
               sq = {};
               for (int i = 0; i < N; i++) sq.push_back(smem[i]);
               sq.sort();
               for (int i = 0; i < N; i++) smem[i] <= sq[i];
               s_ready <= 1'b1;
            end else begin
               scnt <= scnt - 1;
            end
         end
      end
   end

   // Protocol monitor, sampled mid-cycle
   int         n_start = 0;
   int         n_overlap = 0;
   logic [2:0] wr_q[$];

   always @(negedge clk) begin
      if (nrst) begin
         if (s_start) n_start++;
         if (s_start && s_wr) n_overlap++;
         if (s_wr) wr_q.push_back(s_addr);
      end
   end

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] frame [N];
   int         exp_q[$];
   logic [7:0] got_d [N];
   logic       got_l [N];

   task automatic set_frame(input logic [63:0] p);
      for (int i = 0; i < N; i++) frame[i] = p[63-8*i -: 8];
   endtask

   task automatic rand_frame(input logic [7:0] first, input bit fix_first);
      for (int i = 0; i < N; i++) frame[i] = 8'($urandom);
      if (fix_first) frame[0] = first;
   endtask

   // Sorted expectation: emit each byte value as many times as it occurs
   task automatic compute_exp();
      int c [256];
      exp_q.delete();
      for (int v = 0; v < 256; v++) c[v] = 0;
      for (int i = 0; i < N; i++) c[frame[i]]++;
      for (int v = 0; v < 256; v++)
         for (int k = 0; k < c[v]; k++) exp_q.push_back(v);
   endtask

   task automatic send_frame(input int gap);
      int w;
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b1;
         in_data  = frame[i];
         w = 0;
         while (!in_ready && w < 500) begin tick(); w++; end
         if (w >= 500) chk("in_ready_timeout", 0, 1);
         tick();
         in_valid = 1'b0;
         if (i == 0) chk("busy_after_first_accept", busy, 1);
         if (i < N - 1) repeat (gap) tick();
      end
   endtask

   task automatic drain(input int stall, input bit offer, input logic [7:0] offer_byte);
      int n;
      int cyc;
      logic [7:0] d0;
      logic       l0;
      n = 0;
      cyc = 0;
      out_ready = (stall == 0);
      while (n < N && cyc < 3000) begin
         if (out_valid) begin
            if (stall > 0) begin
               d0 = out_data;
               l0 = out_last;
               if (offer) begin in_valid = 1'b1; in_data = offer_byte; end
               for (int s = 0; s < stall; s++) begin
                  tick(); cyc++;
                  chk("stall_data", out_data, d0);
                  chk("stall_last", out_last, l0);
                  chk("stall_valid", out_valid, 1);
                  if (offer) chk("in_ready_drain", in_ready, 0);
               end
               out_ready = 1'b1;
            end
            got_d[n] = out_data;
            got_l[n] = out_last;
            n++;
            tick(); cyc++;
            if (stall > 0) out_ready = 1'b0;
         end else begin
            tick(); cyc++;
         end
      end
      chk("drain_count", n, N);
      chk("busy_after_last", busy, 0);
      chk("in_ready_after_last", in_ready, 1);
      chk("out_valid_after_last", out_valid, 0);
   endtask

   task automatic run_frame(input string name, input int gap, input int stall,
                            input bit offer, input logic [7:0] offer_byte, input bit check_wr);
      int sb;
      int wb;
      sb = n_start;
      wb = wr_q.size();
      compute_exp();
      send_frame(gap);
      drain(stall, offer, offer_byte);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("%s_data%0d", name, i), got_d[i], exp_q[i]);
         chk($sformatf("%s_last%0d", name, i), got_l[i], (i == N - 1) ? 1 : 0);
      end
      chk({name, "_start_pulses"}, n_start - sb, 1);
      if (check_wr) begin
         chk({name, "_wr_pulses"}, wr_q.size() - wb, N);
         for (int i = 0; i < N && wb + i < wr_q.size(); i++)
            chk($sformatf("%s_wr_addr%0d", name, i), wr_q[wb+i], i);
      end
   endtask

   initial begin
      logic [7:0] nb;
      int w;
      // Reset held with random inputs
      nrst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid  = 1'($urandom);
         in_data   = 8'($urandom);
         out_ready = 1'($urandom);
         tick();
         chk("rst_in_ready", in_ready, 1);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_s_start", s_start, 0);
         chk("rst_s_wr", s_wr, 0);
         chk("rst_s_addr", s_addr, 0);
         chk("rst_out_data", out_data, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      nrst = 1'b1;
      tick();
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_s_start", s_start, 0);
      chk("post_rst_s_wr", s_wr, 0);
      chk("post_rst_s_addr", s_addr, 0);

      // Basic frame, back-to-back
      set_frame(64'h05_03_07_01_00_06_02_04);
      run_frame("basic", 0, 0, 1'b0, 8'h00, 1'b1);

      // Duplicates and extremes
      set_frame(64'h09_09_01_01_FF_00_80_09);
      run_frame("dup", 0, 0, 1'b0, 8'h00, 1'b1);

      // Bursty input, 3 idle cycles between bytes
      set_frame(64'h08_07_06_05_04_03_02_01);
      run_frame("bursty", 3, 0, 1'b0, 8'h00, 1'b1);

      // Backpressure with a byte offered during drain that must be held off
      nb = 8'($urandom);
      rand_frame(8'h00, 1'b0);
      run_frame("bp", 0, 5, 1'b1, nb, 1'b1);
      rand_frame(nb, 1'b1);
      run_frame("held", 0, 0, 1'b0, 8'h00, 1'b1);

      // Reset while the sorter is running
      rand_frame(8'h00, 1'b0);
      w = n_start;
      send_frame(0);
      for (int i = 0; i < 50 && n_start == w; i++) tick();
      chk("abort_start_seen", n_start - w, 1);
      tick();
      nrst = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_s_start", s_start, 0);
      chk("abort_s_wr", s_wr, 0);
      chk("abort_s_addr", s_addr, 0);
      tick();
      tick();
      nrst = 1'b1;
      tick();
      set_frame(64'hC8_64_32_19_0C_06_03_01);
      run_frame("after_abort", 0, 0, 1'b0, 8'h00, 1'b1);

      // Random frames with random gaps and stalls
      for (int f = 0; f < 4; f++) begin
         rand_frame(8'h00, 1'b0);
         run_frame($sformatf("rand%0d", f), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), 1'b0, 8'h00, 1'b1);
      end

      chk("start_during_wr", n_overlap, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sort_streamer.md
# sort_streamer

Stream adapter that wraps the 8-entry byte sorter and feeds it from an upstream valid/ready byte stream. It collects a frame of 8 bytes, writes them into the sorter through its host write port, pulses the sorter's start and waits for its ready flag. It then reads back the 8 sorted bytes through the sorter's host read port and emits them as a valid/ready output stream, with a last-byte marker. It sits directly upstream of the sorter (driving start/wr/addr/datain) and also consumes its dataout.

## Interface
- DATA_W, 8, byte width; must match the sorter.
- ADDR_W, 3, sorter address width; frame length N = 2^ADDR_W = 8.
- READ_LAT, 2, rising edges from the sorter first sampling s_addr (with s_wr=0) to s_dataout being valid.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- nrst  in  1  reset; asynchronous and active-low.
- in_valid  in  1  upstream byte valid.
- in_ready  out  1  block accepts a byte; transfer occurs when in_valid & in_ready at a rising edge.
- in_data  in  DATA_W  upstream byte.
- out_valid  out  1  sorted byte available.
- out_ready  in  1  downstream accepts; transfer occurs when out_valid & out_ready at a rising edge.
- out_data  out  DATA_W  sorted byte.
- out_last  out  1  high with the 8th (largest) byte of a frame.
- busy  out  1  high from the first accepted byte of a frame until its last output transfer.
- s_start  out  1  sorter start pulse.
- s_wr  out  1  sorter write enable.
- s_addr  out  ADDR_W  sorter address, used for writes and reads.
- s_datain  out  DATA_W  sorter write data.
- s_dataout  in  DATA_W  sorter read data.
- s_ready  in  1  sorter idle flag.

## Operation
- States: LOAD, SETTLE, GO, WAIT, FETCH, EMIT.
- All outputs except in_ready are registered. in_ready = (state==LOAD).
- Reset values:
  - State LOAD, frame counter 0.
  - in_ready=1; out_valid=0, out_data=0, out_last=0, busy=0.
  - s_start=0, s_wr=0, s_addr=0, s_datain=0.
- LOAD:
  - On each accepted byte, register s_wr=1, s_addr=cnt, s_datain=in_data for the following cycle, then increment cnt (mod 8).
  - With no accepted byte, s_wr=0.
  - busy is set on the first accept.
  - On accepting byte 7, go to SETTLE.
- SETTLE: one cycle; the last write is presented (s_wr=1). Then go to GO.
- GO: s_wr=0, s_start=1 for exactly one cycle. Then go to WAIT.
- WAIT:
  - s_start=0. s_ready is only sampled from this state onward, so the pre-start high level is never mistaken for completion.
  - On an edge with s_ready=1, go to FETCH with s_addr=0, s_wr=0.
- FETCH:
  - Hold s_addr stable and s_wr=0.
  - On the (READ_LAT+1)th rising edge after entry, capture s_dataout into out_data, set out_valid=1, and set out_last=(s_addr==7). Go to EMIT.
- EMIT:
  - Hold out_data and out_last stable while out_ready=0.
  - On transfer, clear out_valid.
  - If s_addr==7: clear busy and out_last, set s_addr=0, go to LOAD.
  - Otherwise: s_addr+1, go to FETCH.
- Asynchronous reset in any state aborts the frame and discards partial input or output. The sorter shares nrst.

## Timing
- Input: one byte per cycle at full rate; in_ready stays high for the whole of LOAD, including gaps in in_valid.
- Sorter write: byte accepted at edge k is written by the sorter at edge k+2; SETTLE guarantees the last write precedes start.
- If byte 7 is accepted at edge k: s_start is high in the cycle after edge k+1, and the sorter samples it at edge k+2.
- Output: one byte per READ_LAT+2 cycles minimum (FETCH plus a 1-cycle EMIT with out_ready=1).
- First out_valid rises READ_LAT+1 edges after WAIT exit.
- in_ready first returns high in the cycle after the last output transfer.
- in_ready is 0 in all states except LOAD; an in_valid presented then is held off and not lost.
- s_start is never high while s_wr=1.
- s_addr never changes while in FETCH.

## Test plan
- Reset: hold nrst=0 with random inputs -> in_ready=1, out_valid=0, busy=0, s_start=0, s_wr=0, s_addr=0 immediately and after release.
- Basic frame: input 5,3,7,1,0,6,2,4 back-to-back with out_ready=1 -> output 0,1,2,3,4,5,6,7; out_last only on 7; exactly one s_start pulse; busy deasserts after the 8th transfer.
- Duplicates/extremes: input 9,9,1,1,255,0,128,9 -> output 0,1,1,9,9,9,128,255.
- Bursty input: in_valid low for 3 cycles between each byte of 8,7,6,5,4,3,2,1 -> eight s_wr pulses to addresses 0..7 in order; output 1..8.
- Backpressure: out_ready low for 5 cycles on each byte -> out_data/out_last stable while stalled, no byte skipped or duplicated; in_valid offered during drain is not accepted (in_ready=0).
- Reset mid-operation: assert nrst low during WAIT, then run frame 200,100,50,25,12,6,3,1 -> output 1,3,6,12,25,50,100,200; no stale bytes emitted.
